// File: rtl/blink_detector.sv
// Measures high/low/period lengths of an asynchronous square wave, declares lock on stable periods, flags timeout.
// Optional glitch filter on the synchronized input: define BLINK_DETECTOR_GLITCH_FILTER_EN.
module blink_detector #(
    parameter  int MAX_HALF_PERIOD = 25000000,
    parameter  int TOL             = 16,
    parameter  int LOCK_COUNT      = 4,
    localparam int HW              = $clog2(MAX_HALF_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blink_in,
    output logic          level,
    output logic [HW-1:0] high_len,
    output logic [HW-1:0] low_len,
    output logic [HW:0]   period,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_ACQUIRE = 2'd1;
    localparam logic [1:0]    ST_LOCKED  = 2'd2;

    localparam logic [HW-1:0] CNT_MAX   = HW'(MAX_HALF_PERIOD);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);
    localparam logic [HW:0]   TOL_P     = (HW+1)'(TOL);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          din_s;
    logic          din_d_reg;

    logic [HW-1:0] cnt_reg;
    logic [1:0]    state_reg;
    logic [MW-1:0] match_reg;
    logic          have_high_reg;
    logic          have_low_reg;
    logic          first_reg;
    logic [HW:0]   prev_reg;

    logic [HW-1:0] high_len_reg;
    logic [HW-1:0] low_len_reg;
    logic [HW:0]   period_reg;
    logic          meas_valid_reg;
    logic          timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= blink_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef BLINK_DETECTOR_GLITCH_FILTER_EN
    // sync1 is the next synchronizer output, so the four-sample window costs only 3 extra cycles
    logic [1:0] hist_reg;
    logic       filt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b00;
            filt_reg <= 1'b0;
        end else begin
            hist_reg <= {hist_reg[0], sync2_reg};
            if (sync1_reg == sync2_reg && sync2_reg == hist_reg[0] && hist_reg[0] == hist_reg[1])
                filt_reg <= sync1_reg;
        end
    end

    assign din_s = filt_reg;
`else
    assign din_s = sync2_reg;
`endif

    logic          edge_det;
    logic          sat;
    logic [HW:0]   new_period;
    logic [HW:0]   diff;
    logic          is_match;
    logic [MW-1:0] match_inc;

    assign edge_det   = din_s ^ din_d_reg;
    assign sat        = (cnt_reg == CNT_MAX);
    assign new_period = {1'b0, high_len_reg} + {1'b0, cnt_reg};
    assign diff       = (new_period >= prev_reg) ? (new_period - prev_reg) : (prev_reg - new_period);
    assign is_match   = (diff <= TOL_P);
    assign match_inc  = (match_reg == MATCH_MAX) ? MATCH_MAX : (match_reg + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            din_d_reg      <= 1'b0;
            cnt_reg        <= '0;
            state_reg      <= ST_IDLE;
            match_reg      <= '0;
            have_high_reg  <= 1'b0;
            have_low_reg   <= 1'b0;
            first_reg      <= 1'b0;
            prev_reg       <= '0;
            high_len_reg   <= '0;
            low_len_reg    <= '0;
            period_reg     <= '0;
            meas_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            din_d_reg      <= din_s;
            meas_valid_reg <= 1'b0;

            if (edge_det)
                cnt_reg <= HW'(1);
            else if (!sat)
                cnt_reg <= cnt_reg + 1'b1;

            // an edge on the saturation cycle wins over the timeout
            if (edge_det) begin
                if (state_reg == ST_IDLE) begin
                    state_reg   <= ST_ACQUIRE;
                    timeout_reg <= 1'b0;
                    first_reg   <= 1'b1;
                end else if (din_s) begin
                    low_len_reg  <= cnt_reg;
                    have_low_reg <= 1'b1;
                    if (have_high_reg && have_low_reg) begin
                        period_reg     <= new_period;
                        meas_valid_reg <= 1'b1;
                        prev_reg       <= new_period;
                        first_reg      <= 1'b0;
                        if (first_reg) begin
                            match_reg <= '0;
                        end else if (is_match) begin
                            match_reg <= match_inc;
                            if (match_inc == MATCH_MAX)
                                state_reg <= ST_LOCKED;
                        end else begin
                            match_reg <= '0;
                            state_reg <= ST_ACQUIRE;
                        end
                    end
                end else begin
                    high_len_reg  <= cnt_reg;
                    have_high_reg <= 1'b1;
                end
            end else if (sat) begin
                timeout_reg   <= 1'b1;
                state_reg     <= ST_IDLE;
                match_reg     <= '0;
                have_high_reg <= 1'b0;
                have_low_reg  <= 1'b0;
                first_reg     <= 1'b0;
            end
        end
    end

    assign level      = din_s;
    assign high_len   = high_len_reg;
    assign low_len    = low_len_reg;
    assign period     = period_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = (state_reg == ST_LOCKED);
    assign timeout    = timeout_reg;

endmodule
